// File: rtl/button_event_arbiter_if.sv
// Press-event handshake between the button arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// N-channel button front end: 2-flop sync, debounce, rise capture, and
// round-robin serialization of presses onto one valid/ready event port.
module button_event_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DB_CNT = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           btn_async,
  output logic [N-1:0]           btn_level,
  output logic [N-1:0]           evt_lost,
  button_event_arbiter_if.master evt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_n;
  logic [N-1:0]     s1, s2;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     rise, pending, pending_n, grant_mask, lost_n;
  logic [ID_W-1:0]  rr_ptr, rr_n, id_q, id_n, pick;
  logic             valid_q, valid_n, found;
  logic [31:0]      idx;

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_async;
      s2 <= s1;
      for (int unsigned i = 0; i < N; i++) begin
        if (s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DB_CNT - 1)) begin
          btn_level[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is captured on the same edge the debounced level goes 0->1.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < N; i++)
      rise[i] = s2[i] && !btn_level[i] && (cnt[i] == CNT_W'(DB_CNT - 1));
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(rr_ptr) + k) % N;
      if (!found && pending[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    valid_n    = valid_q;
    id_n       = id_q;
    rr_n       = rr_ptr;
    grant_mask = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_mask[pick] = 1'b1;
          valid_n          = 1'b1;
          id_n             = pick;
          rr_n             = pick;
          state_n          = OFFER;
        end
      end
      OFFER: begin
        if (valid_q && evt.evt_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
    endcase
    // A rise coinciding with its own grant survives; otherwise a second press is dropped.
    pending_n = (pending & ~grant_mask) | rise;
    lost_n    = rise & pending & ~grant_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      id_q     <= '0;
      rr_ptr   <= ID_W'(N - 1);
      pending  <= '0;
      evt_lost <= '0;
    end else begin
      state    <= state_n;
      valid_q  <= valid_n;
      id_q     <= id_n;
      rr_ptr   <= rr_n;
      pending  <= pending_n;
      evt_lost <= lost_n;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter with N=4, DB_CNT=4.
`timescale 1ns/1ps
module tb_button_event_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned DB_CNT = 4;
  localparam int unsigned CNT_W  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  btn_async = '0;
  logic [N-1:0]  btn_level, evt_lost;

  button_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

  button_event_arbiter #(.N(N), .ID_W(ID_W), .DB_CNT(DB_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .btn_async(btn_async),
    .btn_level(btn_level), .evt_lost(evt_lost), .evt(evt_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lost_hi [N];
  logic [ID_W-1:0] exp_q [$];
  logic [ID_W-1:0] obs_q [$];
  int              obs_cyc [$];
  logic [ID_W-1:0] e, o;
  int              c, prev_c, lost0;
  logic            bad, seen;

  initial for (int i = 0; i < N; i++) lost_hi[i] = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        obs_q.push_back(evt_if.evt_id);
        obs_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) if (evt_lost[i]) lost_hi[i] = lost_hi[i] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    evt_if.evt_ready = 1'b0;
    btn_async = '0;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); end
    checks++; if (btn_level !== 4'b0000) begin failures++; $display("FAIL reset_level: got %b want 0000", btn_level); end
    checks++; if (evt_lost !== 4'b0000) begin failures++; $display("FAIL reset_lost: got %b want 0000", evt_lost); end
    checks++; if (evt_if.evt_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", evt_if.evt_id); end
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency;
    evt_if.evt_ready = 1'b1;
    btn_async[2] = 1'b1;
    exp_q.push_back(2'd2);
    tick(5);
    checks++; if (btn_level[2] !== 1'b0) begin failures++; $display("FAIL lat_level_edge4: got %b want 0", btn_level[2]); end
    tick(1);
    checks++; if (btn_level[2] !== 1'b1) begin failures++; $display("FAIL lat_level_edge5: got %b want 1", btn_level[2]); end
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_edge5: got %b want 0", evt_if.evt_valid); end
    tick(1);
    checks++; if (evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL lat_valid_edge6: got %b want 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_id !== 2'd2) begin failures++; $display("FAIL lat_id_edge6: got %0d want 2", evt_if.evt_id); end
    tick(1);
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_edge7: got %b want 0", evt_if.evt_valid); end
    btn_async[2] = 1'b0;
    tick(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL lat_event: got none want id %0d", e); end
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) begin failures++; $display("FAIL lat_event: got id %0d want id %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL lat_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_bounce;
    logic [14:0] pat;
    pat = 15'b000000001110111;
    bad = 1'b0;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      btn_async[1] = pat[i];
      tick(1);
      if (btn_level[1] !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL bounce_level: got level 1 want 0"); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_no_event: got %0d events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
    exp_q.push_back(2'd1);
    btn_async[1] = 1'b1;
    tick(6);
    btn_async[1] = 1'b0;
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL bounce_event: got none want id %0d", e); end
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) begin failures++; $display("FAIL bounce_event: got id %0d want id %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_round_robin;
    do_reset();
    evt_if.evt_ready = 1'b1;
    for (int burst = 0; burst < 2; burst++) begin
      btn_async = '1;
      for (int i = 0; i < N; i++) exp_q.push_back(ID_W'(i));
      tick(20);
      btn_async = '0;
      tick(10);
      prev_c = -1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (obs_q.size() == 0) begin failures++; $display("FAIL rr_event%0d: got none want id %0d", burst, e); end
        else begin
          o = obs_q.pop_front(); c = obs_cyc.pop_front();
          if (o !== e) begin failures++; $display("FAIL rr_event%0d: got id %0d want id %0d", burst, o, e); end
          if (prev_c >= 0) begin
            checks++;
            if (c - prev_c != 2) begin failures++; $display("FAIL rr_spacing%0d: got %0d cycles want 2", burst, c - prev_c); end
          end
          prev_c = c;
        end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rr_extra%0d: got %0d extra events want 0", burst, obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
    end
  endtask

  task automatic test_stall_loss;
    evt_if.evt_ready = 1'b0;
    lost0 = lost_hi[3];
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    btn_async[3] = 1'b1; tick(8); btn_async[3] = 1'b0; tick(10);
    checks++; if (evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL stall_held_valid: got %b want 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_id !== 2'd3) begin failures++; $display("FAIL stall_held_id: got %0d want 3", evt_if.evt_id); end
    btn_async[3] = 1'b1; tick(8); btn_async[3] = 1'b0; tick(10);
    checks++; if (lost_hi[3] != lost0) begin failures++; $display("FAIL stall_queued_no_loss: got %0d lost cycles want 0", lost_hi[3] - lost0); end
    btn_async[3] = 1'b1; tick(8); btn_async[3] = 1'b0; tick(10);
    checks++; if (lost_hi[3] - lost0 != 1) begin failures++; $display("FAIL stall_lost_pulse: got %0d lost cycles want 1", lost_hi[3] - lost0); end
    evt_if.evt_ready = 1'b1;
    tick(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL stall_event: got none want id %0d", e); end
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) begin failures++; $display("FAIL stall_event: got id %0d want id %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stall_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_reset_mid_offer;
    evt_if.evt_ready = 1'b0;
    btn_async[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (evt_if.evt_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_offer_timeout: got no offer want offer within 30 cycles"); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", evt_if.evt_valid); end
    checks++; if (btn_level !== 4'b0000) begin failures++; $display("FAIL midrst_level: got %b want 0000", btn_level); end
    checks++; if (evt_lost !== 4'b0000) begin failures++; $display("FAIL midrst_lost: got %b want 0000", evt_lost); end
    tick(2);
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    exp_q.push_back(2'd0);
    tick(6);
    checks++; if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid_edge5: got %b want 0", evt_if.evt_valid); end
    tick(1);
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin failures++; $display("FAIL midrst_offer_edge6: got valid %b id %0d want valid 1 id 0", evt_if.evt_valid, evt_if.evt_id); end
    tick(3);
    btn_async[0] = 1'b0;
    tick(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL midrst_event: got none want id %0d", e); end
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) begin failures++; $display("FAIL midrst_event: got id %0d want id %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_hold_release;
    evt_if.evt_ready = 1'b1;
    btn_async[2] = 1'b1;
    exp_q.push_back(2'd2);
    tick(100);
    btn_async[2] = 1'b0;
    tick(5);
    checks++; if (btn_level[2] !== 1'b1) begin failures++; $display("FAIL hold_level_edge4: got %b want 1", btn_level[2]); end
    tick(1);
    checks++; if (btn_level[2] !== 1'b0) begin failures++; $display("FAIL hold_level_edge5: got %b want 0", btn_level[2]); end
    tick(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL hold_event: got none want id %0d", e); end
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) begin failures++; $display("FAIL hold_event: got id %0d want id %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL hold_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_round_robin();
    test_stall_loss();
    test_reset_mid_offer();
    test_hold_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion by 200000ns");
    $fatal(1);
  end

endmodule
